param_cache: RTL and testbench

PARAM_CACHE -- requirements
Module: param_cache

---
 rtl/param_cache.sv | 220 ++++++++++++++++++++++
 tb/tb_param_cache.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/param_cache.sv
// Set-associative write-back, write-allocate word cache in front of a 128-bit line memory.
// Hits complete in the request cycle; misses go through an optional writeback then a line fill.
module param_cache #(
    parameter int WAYS = 2,
    parameter int SETS = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         mem_read,
    input  logic         mem_write,
    input  logic [1:0]   mem_byte_enable,
    input  logic [15:0]  mem_address,
    input  logic [15:0]  mem_wdata,
    output logic [15:0]  mem_rdata,
    output logic         mem_resp,
    output logic         pmem_read,
    output logic         pmem_write,
    output logic [15:0]  pmem_address,
    output logic [127:0] pmem_wdata,
    input  logic [127:0] pmem_rdata,
    input  logic         pmem_resp,
    output logic [15:0]  hit_count,
    output logic [15:0]  miss_count
);
    localparam int IW = $clog2(SETS);
    localparam int TW = 12 - IW;
    localparam int WW = (WAYS == 4) ? 2 : 1;

    typedef enum logic [1:0] {COMPARE, WRITEBACK, ALLOCATE} state_t;

    state_t          state_q, state_d;
    logic [WAYS-1:0] valid_q [SETS];
    logic [WAYS-1:0] valid_d [SETS];
    logic [WAYS-1:0] dirty_q [SETS];
    logic [WAYS-1:0] dirty_d [SETS];
    logic [2:0]      plru_q [SETS];
    logic [2:0]      plru_d [SETS];
    logic [TW-1:0]   tag_q [WAYS][SETS];
    logic [127:0]    data_q [WAYS][SETS];
    logic [WW-1:0]   victim_q, victim_d;
    logic            after_alloc_q, after_alloc_d;
    logic [15:0]     hit_count_q, hit_count_d;
    logic [15:0]     miss_count_q, miss_count_d;

    logic [IW-1:0]   req_idx;
    logic [TW-1:0]   req_tag;
    logic [6:0]      word_lsb;
    logic            req;
    logic            hit;
    logic [WW-1:0]   hit_way;
    logic            free_found;
    logic [WW-1:0]   free_way;
    logic [1:0]      tree_way;
    logic [WW-1:0]   miss_way;
    logic [127:0]    line_hit;
    logic            line_we;
    logic [WW-1:0]   line_way;
    logic [127:0]    line_new;
    logic            tag_we;
    logic            addr_bit0_unused;

    assign req_idx          = mem_address[3+IW:4];
    assign req_tag          = mem_address[15:4+IW];
    assign word_lsb         = {mem_address[3:1], 4'b0000};
    assign req              = mem_read | mem_write;
    assign addr_bit0_unused = mem_address[0];
    assign line_hit         = data_q[hit_way][req_idx];
    assign mem_rdata        = line_hit[word_lsb +: 16];
    assign hit_count        = hit_count_q;
    assign miss_count       = miss_count_q;

    function automatic logic [2:0] plru_touch(input logic [2:0] cur, input logic [1:0] way);
        logic [2:0] nxt;
        nxt = cur;
        if (WAYS == 4) begin
            case (way)
                2'd0:    begin nxt[0] = 1'b1; nxt[1] = 1'b1; end
                2'd1:    begin nxt[0] = 1'b1; nxt[1] = 1'b0; end
                2'd2:    begin nxt[0] = 1'b0; nxt[2] = 1'b1; end
                default: begin nxt[0] = 1'b0; nxt[2] = 1'b0; end
            endcase
        end else begin
            nxt = {2'b00, ~way[0]};
        end
        return nxt;
    endfunction

    // Lookup and victim choice; the descending scan leaves the lowest invalid way.
    always_comb begin
        hit        = 1'b0;
        hit_way    = '0;
        free_found = 1'b0;
        free_way   = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid_q[req_idx][w] && (tag_q[w][req_idx] == req_tag)) begin
                hit     = 1'b1;
                hit_way = WW'(w);
            end
        end
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid_q[req_idx][w]) begin
                free_found = 1'b1;
                free_way   = WW'(w);
            end
        end
        if (WAYS == 4) begin
            tree_way = {plru_q[req_idx][0],
                        plru_q[req_idx][0] ? plru_q[req_idx][2] : plru_q[req_idx][1]};
        end else begin
            tree_way = {1'b0, plru_q[req_idx][0]};
        end
        miss_way = free_found ? free_way : tree_way[WW-1:0];
    end

    always_comb begin
        state_d       = state_q;
        valid_d       = valid_q;
        dirty_d       = dirty_q;
        plru_d        = plru_q;
        victim_d      = victim_q;
        after_alloc_d = after_alloc_q;
        hit_count_d   = hit_count_q;
        miss_count_d  = miss_count_q;
        line_we       = 1'b0;
        line_way      = hit_way;
        line_new      = line_hit;
        tag_we        = 1'b0;
        mem_resp      = 1'b0;
        pmem_read     = 1'b0;
        pmem_write    = 1'b0;
        pmem_address  = {mem_address[15:4], 4'b0000};
        pmem_wdata    = data_q[victim_q][req_idx];
        case (state_q)
            COMPARE: begin
                after_alloc_d = 1'b0;
                if (req && hit) begin
                    mem_resp        = 1'b1;
                    plru_d[req_idx] = plru_touch(plru_q[req_idx], 2'(hit_way));
                    if (!after_alloc_q) begin
                        hit_count_d = hit_count_q + 16'd1;
                    end
                    if (mem_write) begin
                        line_we = 1'b1;
                        for (int b = 0; b < 2; b++) begin
                            if (mem_byte_enable[b]) begin
                                line_new[word_lsb + 7'(b * 8) +: 8] = mem_wdata[b*8 +: 8];
                            end
                        end
                        dirty_d[req_idx][hit_way] = 1'b1;
                    end
                end else if (req) begin
                    victim_d     = miss_way;
                    miss_count_d = miss_count_q + 16'd1;
                    if (valid_q[req_idx][miss_way] && dirty_q[req_idx][miss_way]) begin
                        state_d = WRITEBACK;
                    end else begin
                        state_d = ALLOCATE;
                    end
                end
            end
            WRITEBACK: begin
                pmem_write   = 1'b1;
                pmem_address = {tag_q[victim_q][req_idx], req_idx, 4'b0000};
                if (pmem_resp) begin
                    state_d = ALLOCATE;
                end
            end
            ALLOCATE: begin
                pmem_read = 1'b1;
                if (pmem_resp) begin
                    line_we                    = 1'b1;
                    line_way                   = victim_q;
                    line_new                   = pmem_rdata;
                    tag_we                     = 1'b1;
                    valid_d[req_idx][victim_q] = 1'b1;
                    dirty_d[req_idx][victim_q] = 1'b0;
                    after_alloc_d              = 1'b1;
                    state_d                    = COMPARE;
                end
            end
            default: state_d = COMPARE;
        endcase
        if (!rst_n) begin
            mem_resp   = 1'b0;
            pmem_read  = 1'b0;
            pmem_write = 1'b0;
        end
    end

    // Tag and data arrays are not reset; valid bits alone make them meaningful.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= COMPARE;
            victim_q      <= '0;
            after_alloc_q <= 1'b0;
            hit_count_q   <= 16'd0;
            miss_count_q  <= 16'd0;
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                dirty_q[s] <= '0;
                plru_q[s]  <= '0;
            end
        end else begin
            state_q       <= state_d;
            victim_q      <= victim_d;
            after_alloc_q <= after_alloc_d;
            hit_count_q   <= hit_count_d;
            miss_count_q  <= miss_count_d;
            valid_q       <= valid_d;
            dirty_q       <= dirty_d;
            plru_q        <= plru_d;
            if (line_we) begin
                data_q[line_way][req_idx] <= line_new;
            end
            if (tag_we) begin
                tag_q[victim_q][req_idx] <= req_tag;
            end
        end
    end
endmodule

// File: tb/tb_param_cache.sv
// Bench for param_cache: a 2-way and a 4-way instance checked against a flat-memory
// reference, a directed vector table, reset abort and hit counter wrap sequences.
module tb_param_cache;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n   [2];
    logic         m_read  [2];
    logic         m_write [2];
    logic [1:0]   m_be    [2];
    logic [15:0]  m_addr  [2];
    logic [15:0]  m_wdata [2];
    logic [15:0]  m_rdata [2];
    logic         m_resp  [2];
    logic         p_rd    [2];
    logic         p_wr    [2];
    logic [15:0]  p_addr  [2];
    logic [127:0] p_wdata [2];
    logic [127:0] p_rdata [2];
    logic         p_resp  [2];
    logic [15:0]  hits    [2];
    logic [15:0]  misses  [2];

    param_cache #(.WAYS(2), .SETS(8)) dut_w2 (
        .clk(clk), .rst_n(rst_n[0]), .mem_read(m_read[0]), .mem_write(m_write[0]),
        .mem_byte_enable(m_be[0]), .mem_address(m_addr[0]), .mem_wdata(m_wdata[0]),
        .mem_rdata(m_rdata[0]), .mem_resp(m_resp[0]), .pmem_read(p_rd[0]),
        .pmem_write(p_wr[0]), .pmem_address(p_addr[0]), .pmem_wdata(p_wdata[0]),
        .pmem_rdata(p_rdata[0]), .pmem_resp(p_resp[0]), .hit_count(hits[0]),
        .miss_count(misses[0]));

    param_cache #(.WAYS(4), .SETS(8)) dut_w4 (
        .clk(clk), .rst_n(rst_n[1]), .mem_read(m_read[1]), .mem_write(m_write[1]),
        .mem_byte_enable(m_be[1]), .mem_address(m_addr[1]), .mem_wdata(m_wdata[1]),
        .mem_rdata(m_rdata[1]), .mem_resp(m_resp[1]), .pmem_read(p_rd[1]),
        .pmem_write(p_wr[1]), .pmem_address(p_addr[1]), .pmem_wdata(p_wdata[1]),
        .pmem_rdata(p_rdata[1]), .pmem_resp(p_resp[1]), .hit_count(hits[1]),
        .miss_count(misses[1]));

    int n_vec  = 0;
    int n_fail = 0;
    logic [127:0] bmem [int];
    logic [127:0] rmodel [int];
    int exp_hit [2];
    int exp_miss [2];

    typedef struct {
        int          d;
        bit          wr;
        logic [15:0] a;
        logic [1:0]  be;
        logic [15:0] wd;
        logic [15:0] erd;
        int          eprd;
        int          epwr;
        logic [15:0] ewb;
    } vec_t;
    vec_t tbl [$];

    // Memory contents before any write: each word holds its own address xor 0x5A00.
    function automatic logic [127:0] init_line(input logic [15:0] la);
        logic [127:0] l;
        for (int w = 0; w < 8; w++) l[w*16 +: 16] = ({la[15:4], 4'b0} | 16'(w * 2)) ^ 16'h5A00;
        return l;
    endfunction

    function automatic int key(input int d, input logic [15:0] a);
        return d * 65536 + int'({a[15:4], 4'b0});
    endfunction

    function automatic logic [127:0] mem_get(input int k);
        return bmem.exists(k) ? bmem[k] : init_line(16'(k));
    endfunction

    function automatic logic [127:0] ref_get(input int k);
        return rmodel.exists(k) ? rmodel[k] : mem_get(k);
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic access(input int d, input bit wr, input logic [15:0] a, input logic [1:0] be,
                          input logic [15:0] wd, output logic [15:0] rd, output int nrd,
                          output int nwr, output logic [15:0] wba);
        int lat;
        bit done;
        nrd = 0; nwr = 0; wba = '0; rd = '0; done = 0;
        m_read[d] = !wr; m_write[d] = wr; m_addr[d] = a; m_be[d] = be; m_wdata[d] = wd;
        lat = $urandom_range(0, 2);
        for (int c = 0; c < 60 && !done; c++) begin
            @(negedge clk);
            p_resp[d] = 1'b0;
            if (m_resp[d]) begin
                rd = m_rdata[d];
                done = 1;
            end else if (p_rd[d] && p_wr[d]) begin
                n_fail++;
                $display("FAIL pmem_overlap: dut %0d read and write both high", d);
            end else if (p_rd[d] || p_wr[d]) begin
                if (lat == 0) begin
                    p_resp[d] = 1'b1;
                    lat = $urandom_range(0, 2);
                    chk("pmem_align", 128'(p_addr[d][3:0]), 128'(0));
                    if (p_wr[d]) begin
                        nwr++;
                        wba = p_addr[d];
                        chk("wb_data", p_wdata[d], ref_get(key(d, p_addr[d])));
                        bmem[key(d, p_addr[d])] = p_wdata[d];
                    end else begin
                        nrd++;
                        chk("fill_addr", 128'(p_addr[d]), 128'({a[15:4], 4'b0}));
                        p_rdata[d] = mem_get(key(d, p_addr[d]));
                    end
                end else begin
                    lat--;
                end
            end
        end
        if (!done) begin
            n_fail++;
            $display("FAIL timeout: dut %0d addr %0h got no mem_resp, required one", d, a);
        end
        @(posedge clk);
        #1;
        m_read[d] = 1'b0;
        m_write[d] = 1'b0;
    endtask

    task automatic do_op(input int d, input bit wr, input logic [15:0] a, input logic [1:0] be,
                         input logic [15:0] wd, output logic [15:0] rd, output int nrd,
                         output int nwr, output logic [15:0] wba);
        logic [127:0] line;
        int k;
        k = key(d, a);
        access(d, wr, a, be, wd, rd, nrd, nwr, wba);
        line = ref_get(k);
        if (wr) begin
            for (int b = 0; b < 2; b++)
                if (be[b]) line[a[3:1]*16 + b*8 +: 8] = wd[b*8 +: 8];
            rmodel[k] = line;
        end else begin
            chk("read_data", 128'(rd), 128'(line[a[3:1]*16 +: 16]));
        end
        if (nrd > 0) exp_miss[d]++;
        else exp_hit[d]++;
        chk("hit_count", 128'(hits[d]), 128'(16'(exp_hit[d])));
        chk("miss_count", 128'(misses[d]), 128'(16'(exp_miss[d])));
    endtask

    // Reset drops every cached line, so the reference reverts to backing memory.
    task automatic resync(input int d);
        foreach (rmodel[k]) if (k / 65536 == d) rmodel[k] = mem_get(k);
        exp_hit[d] = 0;
        exp_miss[d] = 0;
    endtask

    task automatic do_reset(input int d);
        rst_n[d] = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_pmem_read", 128'(p_rd[d]), 128'(0));
        rst_n[d] = 1'b1;
        resync(d);
        chk("rst_hit_count", 128'(hits[d]), 128'(0));
        chk("rst_miss_count", 128'(misses[d]), 128'(0));
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] rd, wba, a;
        int nrd, nwr;
        bit seen;

        for (int d = 0; d < 2; d++) begin
            rst_n[d] = 1'b0; m_read[d] = 1'b0; m_write[d] = 1'b0; m_be[d] = 2'b00;
            m_addr[d] = '0; m_wdata[d] = '0; p_rdata[d] = '0; p_resp[d] = 1'b0;
            exp_hit[d] = 0; exp_miss[d] = 0;
        end
        repeat (2) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            chk("reset_hits", 128'(hits[d]), 128'(0));
            chk("reset_misses", 128'(misses[d]), 128'(0));
            chk("reset_pmem_read", 128'(p_rd[d]), 128'(0));
            chk("reset_pmem_write", 128'(p_wr[d]), 128'(0));
            rst_n[d] = 1'b1;
        end

        // 2-way: first-read fill, byte write, LRU eviction of a dirty line
        tbl.push_back('{0, 0, 16'h1234, 2'b00, 16'h0000, 16'h4834, 1, 0, 16'h0000});
        tbl.push_back('{0, 1, 16'h1234, 2'b01, 16'hBEEF, 16'h0000, 0, 0, 16'h0000});
        tbl.push_back('{0, 0, 16'h1234, 2'b00, 16'h0000, 16'h48EF, 0, 0, 16'h0000});
        tbl.push_back('{0, 0, 16'h1000, 2'b00, 16'h0000, 16'h4A00, 1, 0, 16'h0000});
        tbl.push_back('{0, 0, 16'h2000, 2'b00, 16'h0000, 16'h7A00, 1, 0, 16'h0000});
        tbl.push_back('{0, 1, 16'h1000, 2'b11, 16'h1111, 16'h0000, 0, 0, 16'h0000});
        tbl.push_back('{0, 0, 16'h2000, 2'b00, 16'h0000, 16'h7A00, 0, 0, 16'h0000});
        tbl.push_back('{0, 0, 16'h3000, 2'b00, 16'h0000, 16'h6A00, 1, 1, 16'h1000});
        tbl.push_back('{0, 0, 16'h2000, 2'b00, 16'h0000, 16'h7A00, 0, 0, 16'h0000});
        tbl.push_back('{0, 0, 16'h1000, 2'b00, 16'h0000, 16'h1111, 1, 0, 16'h0000});
        // 4-way: fill ways 0..3, tree-PLRU victims way0 then way2
        tbl.push_back('{1, 0, 16'h1000, 2'b00, 16'h0000, 16'h4A00, 1, 0, 16'h0000});
        tbl.push_back('{1, 0, 16'h2000, 2'b00, 16'h0000, 16'h7A00, 1, 0, 16'h0000});
        tbl.push_back('{1, 0, 16'h3000, 2'b00, 16'h0000, 16'h6A00, 1, 0, 16'h0000});
        tbl.push_back('{1, 0, 16'h4000, 2'b00, 16'h0000, 16'h1A00, 1, 0, 16'h0000});
        tbl.push_back('{1, 0, 16'h5000, 2'b00, 16'h0000, 16'h0A00, 1, 0, 16'h0000});
        tbl.push_back('{1, 0, 16'h2000, 2'b00, 16'h0000, 16'h7A00, 0, 0, 16'h0000});
        tbl.push_back('{1, 0, 16'h1000, 2'b00, 16'h0000, 16'h4A00, 1, 0, 16'h0000});
        tbl.push_back('{1, 0, 16'h4000, 2'b00, 16'h0000, 16'h1A00, 0, 0, 16'h0000});
        tbl.push_back('{1, 0, 16'h3000, 2'b00, 16'h0000, 16'h6A00, 1, 0, 16'h0000});

        foreach (tbl[i]) begin
            do_op(tbl[i].d, tbl[i].wr, tbl[i].a, tbl[i].be, tbl[i].wd, rd, nrd, nwr, wba);
            if (!tbl[i].wr) chk("tbl_rdata", 128'(rd), 128'(tbl[i].erd));
            chk("tbl_fills", 128'(nrd), 128'(tbl[i].eprd));
            chk("tbl_writebacks", 128'(nwr), 128'(tbl[i].epwr));
            if (tbl[i].epwr > 0) chk("tbl_wb_addr", 128'(wba), 128'(tbl[i].ewb));
        end

        // Reset while a line fill is outstanding
        m_read[0] = 1'b1; m_write[0] = 1'b0; m_addr[0] = 16'h7770;
        seen = 0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk);
            if (p_rd[0]) seen = 1;
        end
        chk("abort_fill_started", 128'(seen), 128'(1));
        rst_n[0] = 1'b0;
        #1;
        chk("abort_pmem_read_in_reset", 128'(p_rd[0]), 128'(0));
        @(posedge clk);
        #1;
        chk("abort_pmem_read_after", 128'(p_rd[0]), 128'(0));
        m_read[0] = 1'b0;
        rst_n[0] = 1'b1;
        resync(0);
        @(posedge clk);
        #1;
        chk("abort_pmem_read_idle", 128'(p_rd[0]), 128'(0));
        do_op(0, 0, 16'h7770, 2'b00, 16'h0000, rd, nrd, nwr, wba);
        chk("abort_refetch_miss", 128'(nrd), 128'(1));

        // Random traffic on a few conflicting lines
        for (int i = 0; i < 600; i++) begin
            a = (16'($urandom_range(0, 7)) << 12) | (16'($urandom_range(0, 1)) << 4)
              | 16'($urandom_range(0, 15));
            do_op(i % 2, bit'($urandom_range(0, 1)), a, 2'($urandom_range(0, 3)),
                  16'($urandom), rd, nrd, nwr, wba);
        end

        // Hit counter wrap
        for (int d = 0; d < 2; d++) begin
            do_reset(d);
            do_op(d, 0, 16'h0100, 2'b00, 16'h0000, rd, nrd, nwr, wba);
        end
        m_read[0] = 1'b1; m_read[1] = 1'b1;
        repeat (65535) @(posedge clk);
        #1;
        m_read[0] = 1'b0; m_read[1] = 1'b0;
        for (int d = 0; d < 2; d++) begin
            exp_hit[d] += 65535;
            chk("hit_count_ffff", 128'(hits[d]), 128'(16'hFFFF));
            do_op(d, 0, 16'h0100, 2'b00, 16'h0000, rd, nrd, nwr, wba);
            chk("hit_count_wrap", 128'(hits[d]), 128'(16'h0000));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
